tile_spawner: RTL and testbench
===============================

# tile_spawner

Spawns a new tile onto the 4×4 board of the 2048 game after each valid move. On a `start` pulse it snapshots the board and a 32-bit random word from the free-running LFSR. It picks one empty cell uniformly-ish, chooses a value of 2 (≈90%) or 4 (≈10%), and issues a single-cycle write to the board register file. It sits between the 32-bit random source (upstream) and the board state/move logic (downstream).

## Interface

**Parameters**
- `FOUR_THRESHOLD`, default 26: if `rnd[15:8]` is below this value, the new tile is a 4; otherwise it is a 2.

**Ports**
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to spawn a tile. Sampled only in IDLE.
- `board` input 64: cell i occupies bits `[4i+3:4i]` and holds a tile exponent. 0 means empty; 1 = 2, 2 = 4, and so on.
- `rnd` input 32: random word from the LFSR, sampled with `start`.
- `busy` output 1: high from the cycle after `start` is accepted until the cycle after `done`.
- `done` output 1: one-cycle completion pulse.
- `spawned` output 1: valid with `done`. 1 = a tile was written; 0 = the board was full.
- `wr_en` output 1: one-cycle write strobe.
- `wr_idx` output 4: cell index of the write.
- `wr_val` output 4: exponent to write, either 1 or 2.

## Operation

**Reset.** Clears all outputs to 0, the FSM to IDLE, and all counters to 0.

**Accepting a request.** In IDLE, `start=1` latches `board` into `brd_q` and `rnd` into `rnd_q`, then moves the FSM to COUNT. `start` is ignored in every other state. Changes to `board` or `rnd` after acceptance have no effect.

**FSM states:**
- **IDLE:** wait for `start`.
- **COUNT:** runs 16 cycles with scan index `idx` = 0..15. When cell `idx` of `brd_q` is 0, increment the 5-bit `n_empty`, which ranges 0..16. After `idx`=15, go to PICK.
- **PICK:** one cycle.
  - If `n_empty`=0: assert `done`=1 and `spawned`=0, keep `wr_en`=0, and go to IDLE.
  - Otherwise register `k = (rnd_q[7:0] * n_empty) >> 8`. This is a 13-bit product, so `k` ranges 0..n_empty−1. Register `val = (rnd_q[15:8] < FOUR_THRESHOLD) ? 2 : 1`. Clear `idx` and `seen`, then go to SELECT.
- **SELECT:** one cell per cycle, `idx` = 0..15. When cell `idx` is empty:
  - If `seen == k`: assert `wr_en`=1, `wr_idx`=`idx`, `wr_val`=`val`, `done`=1, `spawned`=1, and go to IDLE.
  - Otherwise increment `seen`.
  - A hit is guaranteed by construction. If `idx`=15 passes with no hit, the FSM returns to IDLE with `done`=1 and `spawned`=0. This is a defensive path only.

**Output validity.**
- `wr_idx`, `wr_val` and `spawned` are meaningful only while `done`/`wr_en` is high. Otherwise they hold 0.
- `wr_en` is never high without `done`.

**Reset mid-operation.** `rst` in any state aborts immediately. No `wr_en` or `done` is emitted, and `busy`=0 on the following cycle.

**Back-to-back requests.** A `start` in the same cycle as `done` is ignored, because the FSM is not yet in IDLE. A `start` one cycle later is accepted.

## Timing

- All outputs are registered.
- `start` is sampled at cycle 0. COUNT covers cycles 1–16, PICK is cycle 17, and SELECT scans cell j at cycle 18+j.
- Full board: `done` (with `spawned`=0) is asserted during cycle 17.
- Chosen cell j: `wr_en`/`done` are asserted during cycle 18+j. Worst-case latency is cycle 33.
- `busy` is 1 during cycles 1 through the `done` cycle, and 0 the cycle after.
- Throughput: one request per at most 35 cycles. This is well within one VGA frame.

## Test plan

- **Single empty cell.** Board = all cells 1 except cell 5 = 0; `rnd` = 0xFFFF_FFFF. Expect `wr_en`=1, `wr_idx`=5, `wr_val`=1 at cycle 23, then `spawned`=1.
- **Full board.** Board = 0x1111_1111_1111_1111. Expect `done`=1 and `spawned`=0 at cycle 17, with `wr_en` never asserted.
- **Empty board, 4-tile.** Board = 0; `rnd[15:0]` = 0x1980. Expect `n_empty`=16, k=8, `wr_idx`=8, `wr_val`=2 at cycle 26.
- **Threshold boundary.** Same board, `rnd[15:0]` = 0x1A00. Expect k=0, `wr_idx`=0, `wr_val`=1 at cycle 18.
- **Ignored start and snapshot.** Pulse `start` at cycle 5 and flip `board` to all-full at cycle 3. The result must still match the board latched at cycle 0, with exactly one `done`.
- **Reset mid-SELECT.** Assert `rst` at cycle 19 on an empty board with k=8. Expect no `wr_en` and no `done`, `busy`=0 at cycle 20, and a fresh `start` accepted normally afterwards.

Source files
------------

// File: rtl/tile_spawner.sv
// tile_spawner: places a new 2048 tile (exponent 1 or 2) on a random empty
// cell of the 4x4 board after each move.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - one-cycle spawn request, honoured only when idle
//   board[63:0]     - board snapshot source, cell i at [4i+3:4i], 0 = empty
//   rnd[31:0]       - random word, sampled together with start
//   busy            - high from the cycle after start up to the done cycle
//   done            - one-cycle completion pulse
//   spawned         - with done: 1 = tile written, 0 = board was full
//   wr_en           - one-cycle board write strobe (always with done)
//   wr_idx, wr_val  - cell index and exponent of the write
//
// All outputs are registered, so every output decision is taken one cycle
// ahead: COUNT flags a full board while scanning the last cell, PICK already
// probes cell 0, and SELECT at cell j probes cell j+1.
module tile_spawner #(
    parameter int unsigned FOUR_THRESHOLD = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] board,
    input  logic [31:0] rnd,
    output logic        busy,
    output logic        done,
    output logic        spawned,
    output logic        wr_en,
    output logic [3:0]  wr_idx,
    output logic [3:0]  wr_val
);

    typedef enum logic [1:0] {IDLE, COUNT, PICK, SELECT} state_t;

    state_t      state_q, state_d;
    logic [63:0] brd_q, brd_d;
    logic [15:0] rnd_q, rnd_d;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  n_empty_q, n_empty_d;
    logic [4:0]  seen_q, seen_d;
    logic [4:0]  k_q, k_d;
    logic [3:0]  val_q, val_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        spawned_q, spawned_d;
    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_idx_q, wr_idx_d;
    logic [3:0]  wr_val_q, wr_val_d;

    logic [4:0]  cnt;
    logic [3:0]  probe;

    // Only the low half of the random word drives the choice.
    logic unused_rnd_hi;
    assign unused_rnd_hi = ^rnd[31:16];

    function automatic logic cell_empty(input logic [63:0] b, input logic [3:0] i);
        return b[{i, 2'b00} +: 4] == 4'd0;
    endfunction

    always_comb begin
        state_d   = state_q;
        brd_d     = brd_q;
        rnd_d     = rnd_q;
        idx_d     = idx_q;
        n_empty_d = n_empty_q;
        seen_d    = seen_q;
        k_d       = k_q;
        val_d     = val_q;
        done_d    = 1'b0;
        spawned_d = 1'b0;
        wr_en_d   = 1'b0;
        wr_idx_d  = 4'd0;
        wr_val_d  = 4'd0;
        cnt       = 5'd0;
        probe     = 4'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    brd_d     = board;
                    rnd_d     = rnd[15:0];
                    idx_d     = 4'd0;
                    n_empty_d = 5'd0;
                    state_d   = COUNT;
                end
            end

            COUNT: begin
                cnt       = n_empty_q + {4'd0, cell_empty(brd_q, idx_q)};
                n_empty_d = cnt;
                idx_d     = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = PICK;
                    // Full board: done must already be visible during PICK.
                    if (cnt == 5'd0) done_d = 1'b1;
                end
            end

            PICK: begin
                if (n_empty_q == 5'd0) begin
                    state_d = IDLE;
                end else begin
                    // 8x5-bit product; the top five bits give k in 0..n_empty-1.
                    k_d     = 5'(({5'd0, rnd_q[7:0]} * {8'd0, n_empty_q}) >> 8);
                    val_d   = ({24'd0, rnd_q[15:8]} < FOUR_THRESHOLD) ? 4'd2 : 4'd1;
                    idx_d   = 4'd0;
                    seen_d  = 5'd0;
                    state_d = SELECT;
                    if (cell_empty(brd_q, 4'd0)) begin
                        if (k_d == 5'd0) begin
                            wr_en_d   = 1'b1;
                            wr_idx_d  = 4'd0;
                            wr_val_d  = val_d;
                            done_d    = 1'b1;
                            spawned_d = 1'b1;
                        end else begin
                            seen_d = 5'd1;
                        end
                    end
                end
            end

            SELECT: begin
                if (done_q) begin
                    // Completion pulse is on the outputs this cycle; leave now.
                    state_d = IDLE;
                end else if (idx_q == 4'd15) begin
                    // Unreachable while n_empty > 0; closes the request safely.
                    done_d = 1'b1;
                end else begin
                    probe = idx_q + 4'd1;
                    idx_d = probe;
                    if (cell_empty(brd_q, probe)) begin
                        if (seen_q == k_q) begin
                            wr_en_d   = 1'b1;
                            wr_idx_d  = probe;
                            wr_val_d  = val_q;
                            done_d    = 1'b1;
                            spawned_d = 1'b1;
                        end else begin
                            seen_d = seen_q + 5'd1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            brd_q     <= '0;
            rnd_q     <= '0;
            idx_q     <= '0;
            n_empty_q <= '0;
            seen_q    <= '0;
            k_q       <= '0;
            val_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spawned_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            brd_q     <= brd_d;
            rnd_q     <= rnd_d;
            idx_q     <= idx_d;
            n_empty_q <= n_empty_d;
            seen_q    <= seen_d;
            k_q       <= k_d;
            val_q     <= val_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            spawned_q <= spawned_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_val_q  <= wr_val_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign spawned = spawned_q;
    assign wr_en   = wr_en_q;
    assign wr_idx  = wr_idx_q;
    assign wr_val  = wr_val_q;

endmodule

// File: tb/tb_tile_spawner.sv
module tb_tile_spawner;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] board;
    logic [31:0] rnd;
    logic        busy, done, spawned, wr_en;
    logic [3:0]  wr_idx, wr_val;

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] FULL = 64'h1111_1111_1111_1111;

    tile_spawner #(.FOUR_THRESHOLD(26)) dut (
        .clk(clk), .rst(rst), .start(start), .board(board), .rnd(rnd),
        .busy(busy), .done(done), .spawned(spawned), .wr_en(wr_en),
        .wr_idx(wr_idx), .wr_val(wr_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count empties, scale the random byte, take the k-th empty
    // cell in index order; cycle numbering counts from the start cycle.
    task automatic model(input logic [63:0] b, input logic [31:0] r,
                         output int dcyc, output bit sp, output int widx, output int wval);
        int n, k, m;
        n = 0;
        for (int i = 0; i < 16; i++) if (b[4*i +: 4] == 4'd0) n++;
        dcyc = 17; sp = 0; widx = 0; wval = 0;
        if (n > 0) begin
            k = (int'(r[7:0]) * n) / 256;
            m = 0;
            for (int i = 0; i < 16; i++) begin
                if (b[4*i +: 4] == 4'd0) begin
                    if (m == k) widx = i;
                    m++;
                end
            end
            sp   = 1;
            dcyc = 18 + widx;
            wval = (int'(r[15:8]) < 26) ? 2 : 1;
        end
    endtask

    // One request; flip_c/start_c/rst_c inject board change, extra start
    // pulse, or reset during the given cycle (-1 = none).
    task automatic run(input logic [63:0] b, input logic [31:0] r,
                       input int flip_c, input int start_c, input int rst_c);
        int  dcyc, widx, wval;
        bit  sp, exp_busy, exp_done;
        model(b, r, dcyc, sp, widx, wval);
        @(posedge clk); #1;
        board = b; rnd = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rnd   = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rst_c > 0) exp_busy = (c <= rst_c) && (c <= dcyc);
            else           exp_busy = (c <= dcyc);
            exp_done = (c == dcyc) && !(rst_c > 0 && c > rst_c);
            chk("busy",    32'(busy),    32'(exp_busy));
            chk("done",    32'(done),    32'(exp_done));
            chk("wr_en",   32'(wr_en),   32'(exp_done && sp));
            chk("spawned", 32'(spawned), 32'(exp_done && sp));
            chk("wr_idx",  32'(wr_idx),  (exp_done && sp) ? 32'(widx) : 32'd0);
            chk("wr_val",  32'(wr_val),  (exp_done && sp) ? 32'(wval) : 32'd0);
            start = (c == start_c);
            rst   = (c == rst_c);
            if (c == flip_c) board = FULL;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        logic [63:0] b;
        int          pct;
        rst = 1'b1; start = 1'b0; board = '0; rnd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_done",    32'(done),    0);
        chk("rst_wr_en",   32'(wr_en),   0);
        chk("rst_spawned", 32'(spawned), 0);
        chk("rst_wr_idx",  32'(wr_idx),  0);
        chk("rst_wr_val",  32'(wr_val),  0);
        rst = 1'b0;

        run(64'h1111_1111_1101_1111, 32'hFFFF_FFFF, -1, -1, -1); // cell 5 at cycle 23
        run(FULL,                    32'h1234_5678, -1, -1, -1); // full, done at 17
        run(64'h0,                   32'h0000_1980, -1, -1, -1); // idx 8, value 4
        run(64'h0,                   32'h0000_1A00, -1, 18, -1); // idx 0, value 2, start at done ignored
        run(64'h0120_0300_4005_0067, 32'h0000_05C3,  3,  5, -1); // snapshot + ignored start
        run(64'h0,                   32'h0000_1980, -1, -1, 19); // reset mid-SELECT
        run(64'h0,                   32'h0000_1980, -1, -1, -1); // fresh start after reset
        run(64'h0111_1111_1111_1111, 32'h0000_00FF, -1, -1, -1); // last cell, cycle 33

        for (int t = 0; t < 40; t++) begin
            pct = (t % 10 == 9) ? 0 : $urandom_range(5, 100);
            for (int i = 0; i < 16; i++)
                b[4*i +: 4] = ($urandom_range(0, 99) < pct) ? 4'd0 : 4'($urandom_range(1, 11));
            run(b, $urandom, -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
